// File: rtl/timer_controller.sv
// -----------------------------------------------------------------------------
// timer_controller
//
// Sequencing controller for a kitchen-timer down-counter chain
// (minutes units mod 10, seconds tens mod 6, seconds units mod 10).
//  - Collects keypad digits into a 3-digit BCD preset (load_data).
//  - Runs IDLE -> LOAD -> RUN <-> PAUSE, RUN -> DONE -> IDLE.
//  - Generates the 1-second decrement strobe (cnt_en) from a prescaler.
//  - Drives the heater (mag_on) and the buzzer (alarm).
//
// Ports
//   clk          system clock, all state on rising edge
//   clearn       asynchronous active-low reset
//   start        start / resume request (level)
//   stop         pause / cancel request (level)
//   door_closed  1 = door closed
//   key_valid    one-cycle strobe qualifying key_digit
//   key_digit    keypad digit (0..9 accepted, others rejected)
//   zero         counter chain reads 0:00
//   cnt_en       chain decrement enable, one cycle per tick
//   cnt_loadn    chain active-low parallel load (low during LOAD)
//   cnt_clearn   chain active-low clear (low in reset and on cancel)
//   load_data    BCD preset {min, sec tens, sec units}
//   mag_on       heater on (RUN only)
//   alarm        buzzer (DONE only)
//   state        IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
//
// All outputs are registered. Each output register is loaded from the
// *next* state so that the output is valid in the same cycle as the
// state it belongs to (e.g. cnt_loadn is low exactly while state==LOAD).
// -----------------------------------------------------------------------------
module timer_controller #(
    parameter int TICK_DIV     = 50000000,
    parameter int ALARM_CYCLES = 100
) (
    input  logic        clk,
    input  logic        clearn,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        zero,
    output logic        cnt_en,
    output logic        cnt_loadn,
    output logic        cnt_clearn,
    output logic [11:0] load_data,
    output logic        mag_on,
    output logic        alarm,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_CYCLES - 1);

    // Registered state
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [AW-1:0] r_alarm_cnt;
    logic [11:0]   r_load_data;
    logic          r_cnt_en;
    logic          r_cnt_loadn;
    logic          r_cnt_clearn;
    logic          r_mag_on;
    logic          r_alarm;

    // Next-state values
    state_t        w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [PW-1:0] w_presc_inc;
    logic [AW-1:0] w_alarm_cnt_nxt;
    logic [11:0]   w_load_data_nxt;
    logic          w_clear_chain;
    logic          w_key_ok;

    // A digit is accepted only if it is decimal and the digit that moves
    // into the seconds-tens position (current units) stays within 0..5.
    assign w_key_ok = key_valid && (key_digit <= 4'd9) && (r_load_data[3:0] <= 4'd5);

    assign w_presc_inc = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_presc_nxt     = r_presc;
        w_alarm_cnt_nxt = '0;
        w_load_data_nxt = r_load_data;
        w_clear_chain   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (stop) begin
                    // stop outranks everything; nothing to cancel here
                end else if (start) begin
                    if (door_closed && (r_load_data != 12'h000)) begin
                        w_state_nxt = ST_LOAD;
                    end
                end else if (w_key_ok) begin
                    w_load_data_nxt = {r_load_data[7:0], key_digit};
                end
            end

            ST_LOAD: begin
                w_presc_nxt = '0;
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                // Every RUN cycle advances the prescaler, including the one
                // in which a pause is detected. A tick already issued in that
                // cycle is therefore wrapped away and never repeated on resume.
                w_presc_nxt = w_presc_inc;
                if (stop || !door_closed) begin
                    w_state_nxt = ST_PAUSE;
                end else if (zero) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    w_state_nxt     = ST_IDLE;
                    w_load_data_nxt = 12'h000;
                    w_clear_chain   = 1'b1;
                end else if (start && door_closed) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                if (stop || (r_alarm_cnt == ALARM_MAX)) begin
                    // Chain already reads 0:00, so no clear pulse is needed.
                    w_state_nxt     = ST_IDLE;
                    w_load_data_nxt = 12'h000;
                end else begin
                    w_alarm_cnt_nxt = r_alarm_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_load_data_nxt = 12'h000;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and evaluation order cannot matter.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_alarm_cnt  <= '0;
            r_load_data  <= 12'h000;
            r_cnt_en     <= 1'b0;
            r_cnt_loadn  <= 1'b1;
            r_cnt_clearn <= 1'b0;
            r_mag_on     <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_alarm_cnt  <= w_alarm_cnt_nxt;
            r_load_data  <= w_load_data_nxt;
            r_cnt_en     <= (w_state_nxt == ST_RUN) && (w_presc_nxt == PRESC_MAX);
            r_cnt_loadn  <= (w_state_nxt != ST_LOAD);
            r_cnt_clearn <= !w_clear_chain;
            r_mag_on     <= (w_state_nxt == ST_RUN);
            r_alarm      <= (w_state_nxt == ST_DONE);
        end
    end

    assign state      = r_state;
    assign load_data  = r_load_data;
    assign cnt_en     = r_cnt_en;
    assign cnt_loadn  = r_cnt_loadn;
    assign cnt_clearn = r_cnt_clearn;
    assign mag_on     = r_mag_on;
    assign alarm      = r_alarm;

endmodule

// File: tb/tb_timer_controller.sv
// -----------------------------------------------------------------------------
// tb_timer_controller
//
// Directed bench for timer_controller with TICK_DIV=4, ALARM_CYCLES=5.
// Inputs are driven and outputs sampled on the falling clock edge, away from
// the active rising edge. The counter chain is not modelled; zero is driven
// directly.
// -----------------------------------------------------------------------------
module tb_timer_controller;

    localparam int TICK_DIV     = 4;
    localparam int ALARM_CYCLES = 5;

    logic        clk = 1'b0;
    logic        clearn;
    logic        start;
    logic        stop;
    logic        door_closed;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        zero;
    logic        cnt_en;
    logic        cnt_loadn;
    logic        cnt_clearn;
    logic [11:0] load_data;
    logic        mag_on;
    logic        alarm;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    int bad;

    timer_controller #(
        .TICK_DIV     (TICK_DIV),
        .ALARM_CYCLES (ALARM_CYCLES)
    ) dut (
        .clk         (clk),
        .clearn      (clearn),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .zero        (zero),
        .cnt_en      (cnt_en),
        .cnt_loadn   (cnt_loadn),
        .cnt_clearn  (cnt_clearn),
        .load_data   (load_data),
        .mag_on      (mag_on),
        .alarm       (alarm),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'h0;
    endtask

    task automatic do_reset();
        clearn = 1'b0;
        step();
        clearn = 1'b1;
        step();
    endtask

    // Pulse start for one cycle; afterwards the DUT is in its LOAD cycle.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        clearn      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        door_closed = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'h0;
        zero        = 1'b0;

        // ---------------- reset values ----------------
        #12;
        check("rst_state",      state,      32'd0);
        check("rst_load_data",  load_data,  32'h000);
        check("rst_cnt_en",     cnt_en,     32'd0);
        check("rst_cnt_loadn",  cnt_loadn,  32'd1);
        check("rst_cnt_clearn", cnt_clearn, 32'd0);
        check("rst_mag_on",     mag_on,     32'd0);
        check("rst_alarm",      alarm,      32'd0);
        step();
        clearn = 1'b1;
        step();
        check("post_rst_clearn", cnt_clearn, 32'd1);

        // ---------------- key entry ----------------
        press_key(4'd1);
        press_key(4'd3);
        press_key(4'd0);
        check("keys_130", load_data, 32'h130);
        press_key(4'd7);
        check("key7_accepted", load_data, 32'h307);
        press_key(4'hA);
        check("keyA_rejected", load_data, 32'h307);

        // start with empty preset is ignored
        do_reset();
        pulse_start();
        check("start_empty_ignored", state, 32'd0);

        // tens guard
        press_key(4'd6);
        check("key6", load_data, 32'h006);
        press_key(4'd2);
        check("tens_guard", load_data, 32'h006);

        // start with door open is ignored
        door_closed = 1'b0;
        pulse_start();
        check("start_door_open", state, 32'd0);
        door_closed = 1'b1;

        // ---------------- load and first tick ----------------
        do_reset();
        press_key(4'd5);
        check("preset_005", load_data, 32'h005);
        pulse_start();
        check("load_state",  state,     32'd1);
        check("load_loadn",  cnt_loadn, 32'd0);
        check("load_cnt_en", cnt_en,    32'd0);
        step();
        check("run_state", state,     32'd2);
        check("run_loadn", cnt_loadn, 32'd1);
        // n counts RUN cycles up to and including the one with cnt_en high
        n   = 1;
        bad = 0;
        while (cnt_en !== 1'b1 && n < 20) begin
            if (mag_on !== 1'b1) bad++;
            step();
            n++;
        end
        check("first_tick_cycle", n, 32'd4);
        step();
        check("tick_width", cnt_en, 32'd0);
        n = 1;
        while (cnt_en !== 1'b1 && n < 20) begin
            if (mag_on !== 1'b1) bad++;
            step();
            n++;
        end
        check("tick_period", n, 32'd4);
        check("mag_on_in_run", bad, 32'd0);

        // ---------------- pause and resume ----------------
        // Now in the tick cycle. Door opens two cycles later.
        step();
        step();
        door_closed = 1'b0;
        step();
        check("pause_state",  state,  32'd3);
        check("pause_mag_on", mag_on, 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (cnt_en !== 1'b0) bad++;
            step();
        end
        check("pause_no_tick", bad, 32'd0);
        door_closed = 1'b1;
        pulse_start();
        check("resume_state", state, 32'd2);
        // prescaler held at 2: tick lands in the second RUN cycle
        n = 1;
        while (cnt_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("resume_tick_cycle", n, 32'd2);

        // ---------------- completion ----------------
        step();
        zero = 1'b1;
        step();
        check("done_state",  state,  32'd4);
        check("done_alarm",  alarm,  32'd1);
        check("done_mag_on", mag_on, 32'd0);
        check("done_cnt_en", cnt_en, 32'd0);
        start = 1'b1;  // held through DONE -> IDLE, must not restart
        n = 1;
        step();
        while (alarm === 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("alarm_cycles",   n,         32'd5);
        check("done_exit_idle", state,     32'd0);
        check("done_exit_load", load_data, 32'h000);
        step();
        step();
        check("start_held_no_restart", state, 32'd0);
        start = 1'b0;
        zero  = 1'b0;

        // ---------------- stop during DONE ----------------
        do_reset();
        press_key(4'd1);
        pulse_start();
        step();
        zero = 1'b1;
        step();
        check("done2_state", state, 32'd4);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        zero = 1'b0;
        check("stop_done_state", state,     32'd0);
        check("stop_done_alarm", alarm,     32'd0);
        check("stop_done_load",  load_data, 32'h000);

        // ---------------- cancel from PAUSE ----------------
        do_reset();
        press_key(4'd2);
        pulse_start();
        step();
        door_closed = 1'b0;
        step();
        check("cancel_pause", state, 32'd3);
        stop = 1'b1;
        step();
        stop        = 1'b0;
        door_closed = 1'b1;
        check("cancel_clearn", cnt_clearn, 32'd0);
        check("cancel_state",  state,      32'd0);
        check("cancel_load",   load_data,  32'h000);
        step();
        check("cancel_clearn_one", cnt_clearn, 32'd1);

        // ---------------- async reset mid-RUN ----------------
        press_key(4'd3);
        pulse_start();
        step();
        step();
        check("pre_reset_mag_on", mag_on, 32'd1);
        #2;
        clearn = 1'b0;
        #1;
        check("async_state",  state,      32'd0);
        check("async_mag_on", mag_on,     32'd0);
        check("async_clearn", cnt_clearn, 32'd0);
        check("async_loadn",  cnt_loadn,  32'd1);
        check("async_load",   load_data,  32'h000);
        check("async_cnt_en", cnt_en,     32'd0);
        check("async_alarm",  alarm,      32'd0);
        step();
        clearn = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
